// File: rtl/key_conditioner_pkg.sv
// Shared board-IO definitions: key FSM encoding, default timing constants
// and the registered key-event payload.
package key_conditioner_pkg;

  // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kc_state_e;

  typedef struct packed {
    logic pressed;
    logic press_pulse;
    logic release_pulse;
  } kc_event_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw key towards the conditioner, debounced
// level and strobes back out.
interface key_conditioner_if;
  logic key_in;
  logic pressed;
  logic press_pulse;
  logic release_pulse;

  modport master (output key_in, input pressed, press_pulse, release_pulse);
  modport slave  (input key_in, output pressed, press_pulse, release_pulse);
endinterface

// File: rtl/key_conditioner_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous board inputs (keys, switches);
// resets to RESET_VAL so a reset releases onto the idle input level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic aclr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronize, debounce, emit registered level plus
// press/release strobes. Define KEY_COND_REPEAT_EN to add auto-repeat while held.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic              clk,
  input logic              aclr,
  key_conditioner_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24) ||
      REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_param
    $error("key_conditioner: timing parameter out of range");
  end

  kc_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  kc_event_t        evt_q, evt_n;
  logic             key_sync;
  logic             s;
  logic             rpt_fire;

  // Idle key level is the reset value so reset never looks like a press
  sync_2ff #(.RESET_VAL(KEY_ACTIVE_LOW)) u_sync (
    .clk  (clk),
    .aclr (aclr),
    .d    (bus.key_in),
    .q    (key_sync)
  );

  assign s       = KEY_ACTIVE_LOW ? ~key_sync : key_sync;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state <= ST_IDLE;
      cnt   <= '0;
      evt_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      evt_q <= evt_n;
    end
  end

  // Strobes decode the registered state against last cycle's level, so they
  // land one cycle after the accepting transition, together with pressed.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    evt_n   = '0;

    case (state)
      ST_IDLE: begin
        if (s) begin
          state_n = ST_PRESS_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_n = ST_RELEASE_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_n = ST_HELD;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    evt_n.pressed       = (state == ST_HELD) || (state == ST_RELEASE_WAIT);
    evt_n.press_pulse   = ((state == ST_HELD) && !evt_q.pressed) || rpt_fire;
    evt_n.release_pulse = (state == ST_IDLE) && evt_q.pressed;
  end

`ifdef KEY_COND_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_n, rpt_target;
  logic             rpt_first, rpt_first_n;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt_n;
      rpt_first <= rpt_first_n;
    end
  end

  // Counts HELD cycles only: frozen in RELEASE_WAIT, cleared in IDLE
  always_comb begin
    rpt_cnt_n   = rpt_cnt;
    rpt_first_n = rpt_first;
    rpt_target  = rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);
    rpt_fire    = 1'b0;

    case (state)
      ST_IDLE: begin
        rpt_cnt_n   = '0;
        rpt_first_n = 1'b1;
      end
      ST_HELD: begin
        if (rpt_cnt == rpt_target) begin
          rpt_fire    = 1'b1;
          rpt_cnt_n   = RPT_W'(1);
          rpt_first_n = 1'b0;
        end else begin
          rpt_cnt_n = rpt_cnt + RPT_W'(1);
        end
      end
      default: ;
    endcase
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign bus.pressed       = evt_q.pressed;
  assign bus.press_pulse   = evt_q.press_pulse;
  assign bus.release_pulse = evt_q.release_pulse;

endmodule
